mfb_protocol_checker: RTL
=========================

// Module: mfb_protocol_checker
// PURPOSE
// - Synthesizable passive monitor for one MFB stream; the next generation of the per-interface bus property checkers.
// - Tracks frame state across all regions of a word and flags SOF/EOF ordering violations.
// - Counts closed packets and error words, and latches sticky and first-error codes.
// - Taps any app-core MFB port (ETH/DMA, RX/TX) in simulation or hardware; it never drives the bus.
// PARAMETERS
// - REGIONS      4   number of MFB regions per word
// - REGION_SIZE  8   blocks per region
// - BLOCK_SIZE   8   items per block
// - ITEM_WIDTH   8   bits per item
// - META_WIDTH   0   metadata bits per region; 0 = no metadata
// - CNT_WIDTH    32  width of PKT_CNT and ERR_CNT
// PORTS
// - CLK          in   1                                  clock
// - RESET        in   1                                  synchronous reset, active-high
// - RX_DATA      in   REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  monitored data
// - RX_META      in   REGIONS*max(META_WIDTH,1)          monitored metadata
// - RX_SOF       in   REGIONS                            start of frame, one bit per region
// - RX_EOF       in   REGIONS                            end of frame, one bit per region
// - RX_SOF_POS   in   REGIONS*max(1,log2(REGION_SIZE))   SOF block index per region
// - RX_EOF_POS   in   REGIONS*max(1,log2(REGION_SIZE*BLOCK_SIZE))  EOF item index per region
// - RX_SRC_RDY   in   1                                  source ready
// - RX_DST_RDY   in   1                                  destination ready
// - CNT_CLR      in   1                                  clear counters and error latches
// - ERR_VLD      out  1                                  pulse: the previous word had an error
// - ERR_VEC      out  3                                  per-cycle error bits of the previous word
// - ERR_STICKY   out  3                                  OR of all errors since reset or clear
// - ERR_FIRST    out  3                                  error vector of the first error word
// - PKT_CNT      out  CNT_WIDTH                          number of correctly closed packets
// - ERR_CNT      out  CNT_WIDTH                          number of words with any error
// BEHAVIOUR
// - Reset: every output is 0; the frame state is IDLE; the stall-tracking register is cleared.
// - Reset mid-frame drops the open frame; that frame is never counted.
// - Error bits: [0] SOF while IN_FRAME, [1] EOF while IDLE, [2] stall instability.
// - Word transfer = RX_SRC_RDY && RX_DST_RDY. SOF/EOF are evaluated only on a transfer.
// - FSM IDLE/IN_FRAME is updated region 0 -> REGIONS-1 in a combinational chain; the end state is registered.
// - Per region r, with sb = SOF_POS*BLOCK_SIZE:
//   - SOF only: IN_FRAME sets err[0]. Next state IN_FRAME (new frame restarts).
//   - EOF only: IDLE sets err[1]. Next state IDLE. A valid close increments the packet count.
//   - SOF&EOF with EOF_POS>=sb: single-region packet. IN_FRAME sets err[0]; the packet is still counted. Next state IDLE.
//   - SOF&EOF with EOF_POS<sb: EOF closes the old frame, then SOF opens a new one. IDLE sets err[1]. Next state IN_FRAME.
//   - Neither bit set: state unchanged.
// - Stall check: if the previous cycle had SRC_RDY=1 && DST_RDY=0, this cycle needs SRC_RDY=1.
//   DATA, META, SOF, EOF, SOF_POS and EOF_POS must also be bit-identical. Any mismatch sets err[2].
// - Latency: ERR_VLD/ERR_VEC are registered and valid 1 cycle after the offending cycle.
// - Counter increments take effect on that same edge.
// - PKT_CNT adds 0..REGIONS per word and saturates at all-ones. ERR_CNT adds 1 per error word and saturates.
// - ERR_FIRST loads only while ERR_STICKY==0.
// - CNT_CLR=1 on an edge sets PKT_CNT, ERR_CNT, ERR_STICKY and ERR_FIRST to 0.
//   It takes priority over same-cycle increments and errors; those are discarded. ERR_VEC/ERR_VLD still report.
//   The FSM is unaffected.
// CONFIGURATION
// - MFB_PROTOCOL_CHECKER_STALL_CHECK_EN defined: stall check and its registered copy of the previous word are built.
// - Not defined: no copy registers are built; err[2] is constant 0.
// - SOF/EOF checking is identical in both builds.
// TESTING
// - REGIONS=4; SOF r0 POS0, EOF r0 POS7, one transfer -> PKT_CNT=1 next cycle, ERR_VEC=0.
// - SOF r1 in word0; SOF r0 in word1 with no EOF between -> ERR_VEC=3'b001, ERR_CNT=1, ERR_FIRST=3'b001.
// - EOF r2 after reset with no SOF -> ERR_VEC=3'b010, PKT_CNT=0, state IDLE.
// - SRC_RDY=1 DST_RDY=0, DATA changes next cycle -> ERR_VEC=3'b100 (STALL_CHECK_EN), else 0.
// - Open frame, RESET pulse, then EOF -> err[1]. Then CNT_CLR with an error in the same cycle -> counters 0, ERR_STICKY=0.
// - CNT_WIDTH=4, 20 single-region packets -> PKT_CNT saturates at 15.

Source files
------------

// File: rtl/mfb_protocol_checker_if.sv
// MFB stream bundle tapped by mfb_protocol_checker.
// master drives the word, slave drives RX_DST_RDY, monitor only observes.
interface mfb_protocol_checker_if #(
    parameter int unsigned REGIONS     = 4,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 0
);
    localparam int unsigned DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int unsigned META_W    = (META_WIDTH > 0) ? META_WIDTH : 1;
    localparam int unsigned SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int unsigned EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 1) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1;

    logic [DATA_W-1:0]            RX_DATA;
    logic [REGIONS*META_W-1:0]    RX_META;
    logic [REGIONS-1:0]           RX_SOF;
    logic [REGIONS-1:0]           RX_EOF;
    logic [REGIONS*SOF_POS_W-1:0] RX_SOF_POS;
    logic [REGIONS*EOF_POS_W-1:0] RX_EOF_POS;
    logic                         RX_SRC_RDY;
    logic                         RX_DST_RDY;

    modport master (
        output RX_DATA, RX_META, RX_SOF, RX_EOF, RX_SOF_POS, RX_EOF_POS, RX_SRC_RDY,
        input  RX_DST_RDY
    );

    modport slave (
        input  RX_DATA, RX_META, RX_SOF, RX_EOF, RX_SOF_POS, RX_EOF_POS, RX_SRC_RDY,
        output RX_DST_RDY
    );

    modport monitor (
        input RX_DATA, RX_META, RX_SOF, RX_EOF, RX_SOF_POS, RX_EOF_POS, RX_SRC_RDY, RX_DST_RDY
    );
endinterface

// File: rtl/mfb_protocol_checker.sv
// Passive MFB monitor: SOF/EOF ordering, optional stall stability, packet/error counters.
// Define MFB_PROTOCOL_CHECKER_STALL_CHECK_EN to build the stall-stability check (err[2]).
module mfb_protocol_checker #(
    parameter int unsigned REGIONS     = 4,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 0,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    mfb_protocol_checker_if.monitor rx,
    input  logic                   CNT_CLR,
    output logic                   ERR_VLD,
    output logic [2:0]             ERR_VEC,
    output logic [2:0]             ERR_STICKY,
    output logic [2:0]             ERR_FIRST,
    output logic [CNT_WIDTH-1:0]   PKT_CNT,
    output logic [CNT_WIDTH-1:0]   ERR_CNT
);
    localparam int unsigned DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int unsigned META_W    = (META_WIDTH > 0) ? META_WIDTH : 1;
    localparam int unsigned SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int unsigned EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 1) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1;
    localparam int unsigned INC_W     = $clog2(REGIONS + 1);
    localparam int unsigned SUM_W     = CNT_WIDTH + 1;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t               state_q, state_d;
    logic                 err_vld_q, err_vld_d;
    logic [2:0]           err_vec_q, err_vec_d;
    logic [2:0]           sticky_q, sticky_d;
    logic [2:0]           first_q, first_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [1:0]           ord_err_c;
    logic                 stall_err_c;
    logic [INC_W-1:0]     pkt_inc_c;
    logic [SUM_W-1:0]     pkt_sum_c;
    logic                 xfer_c;

    assign xfer_c = rx.RX_SRC_RDY && rx.RX_DST_RDY;

    // Frame state walks region 0 -> REGIONS-1; SOF&EOF order decided by EOF item vs SOF start item.
    always_comb begin : frame_chain
        state_t      st;
        logic        sof;
        logic        eof;
        int unsigned sb;
        int unsigned ep;
        st        = state_q;
        ord_err_c = 2'b00;
        pkt_inc_c = '0;
        for (int r = 0; r < int'(REGIONS); r++) begin
            sof = rx.RX_SOF[r];
            eof = rx.RX_EOF[r];
            sb  = 32'(rx.RX_SOF_POS[r*SOF_POS_W +: SOF_POS_W]) * BLOCK_SIZE;
            ep  = 32'(rx.RX_EOF_POS[r*EOF_POS_W +: EOF_POS_W]);
            if (xfer_c) begin
                if (sof && (!eof || ep >= sb)) begin
                    if (st == IN_FRAME) ord_err_c[0] = 1'b1;
                    if (eof) begin
                        pkt_inc_c = pkt_inc_c + INC_W'(1);
                        st        = IDLE;
                    end else begin
                        st = IN_FRAME;
                    end
                end else if (eof) begin
                    if (st == IDLE) ord_err_c[1] = 1'b1;
                    else            pkt_inc_c = pkt_inc_c + INC_W'(1);
                    st = sof ? IN_FRAME : IDLE;
                end
            end
        end
        state_d = st;
    end

`ifdef MFB_PROTOCOL_CHECKER_STALL_CHECK_EN
    localparam bit META_EN = (META_WIDTH > 0);

    logic                         stall_q, stall_d;
    logic [DATA_W-1:0]            data_q;
    logic [REGIONS*META_W-1:0]    meta_q;
    logic [REGIONS-1:0]           sof_q, eof_q;
    logic [REGIONS*SOF_POS_W-1:0] sof_pos_q;
    logic [REGIONS*EOF_POS_W-1:0] eof_pos_q;

    // A word offered but not accepted must be re-offered unchanged.
    always_comb begin
        stall_d     = rx.RX_SRC_RDY && !rx.RX_DST_RDY;
        stall_err_c = stall_q && (!rx.RX_SRC_RDY
                      || rx.RX_DATA    != data_q
                      || (META_EN && rx.RX_META != meta_q)
                      || rx.RX_SOF     != sof_q
                      || rx.RX_EOF     != eof_q
                      || rx.RX_SOF_POS != sof_pos_q
                      || rx.RX_EOF_POS != eof_pos_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) stall_q <= 1'b0;
        else       stall_q <= stall_d;
        data_q    <= rx.RX_DATA;
        meta_q    <= rx.RX_META;
        sof_q     <= rx.RX_SOF;
        eof_q     <= rx.RX_EOF;
        sof_pos_q <= rx.RX_SOF_POS;
        eof_pos_q <= rx.RX_EOF_POS;
    end
`else
    logic unused_payload_c;
    assign unused_payload_c = ^{rx.RX_DATA, rx.RX_META};
    assign stall_err_c      = 1'b0;
`endif

    // Error reporting and saturating counters; CNT_CLR wins over same-cycle updates.
    always_comb begin
        err_vec_d = {stall_err_c, ord_err_c};
        err_vld_d = |err_vec_d;
        pkt_sum_c = {1'b0, pkt_cnt_q} + SUM_W'(pkt_inc_c);
        pkt_cnt_d = pkt_sum_c[CNT_WIDTH] ? '1 : pkt_sum_c[CNT_WIDTH-1:0];
        err_cnt_d = (err_vld_d && err_cnt_q != '1) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
        sticky_d  = sticky_q | err_vec_d;
        first_d   = (sticky_q == 3'b000 && err_vld_d) ? err_vec_d : first_q;
        if (CNT_CLR) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
            sticky_d  = 3'b000;
            first_d   = 3'b000;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            err_vld_q <= 1'b0;
            err_vec_q <= 3'b000;
            sticky_q  <= 3'b000;
            first_q   <= 3'b000;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_vld_q <= err_vld_d;
            err_vec_q <= err_vec_d;
            sticky_q  <= sticky_d;
            first_q   <= first_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_VLD    = err_vld_q;
    assign ERR_VEC    = err_vec_q;
    assign ERR_STICKY = sticky_q;
    assign ERR_FIRST  = first_q;
    assign PKT_CNT    = pkt_cnt_q;
    assign ERR_CNT    = err_cnt_q;
endmodule
